mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//   Memory-side responder for the datapath's MIO handshake: accepts MIO.EN/R.W/DATA.SIZE
//   requests with a MAR address and MDR write data, inserts LATENCY wait states, then
//   completes the access and pulses R for one cycle. Sits between the datapath's memory
//   port and a word-organised RAM array. The microsequencer loops on R as the ready input.
// PARAMETERS
//   LATENCY  3   wait cycles between request acceptance and access completion (>=1)
//   ADDR_W   12  word-address width; array holds 2**ADDR_W 16-bit words
// PORTS
//   clk        in   1   system clock; all state changes on rising edge
//   reset      in   1   asynchronous, active-low reset
//   mio_en     in   1   request valid; held high by the sequencer until R is seen
//   r_w        in   1   1 = write, 0 = read
//   data_size  in   1   1 = word, 0 = byte
//   addr       in   16  byte address (MAR)
//   wdata      in   16  write data (MDR); byte writes use wdata[7:0]
//   rdata      out  16  read word; valid while r=1, held until the next read completes
//   r          out  1   ready; one-cycle pulse when the access completes
// BEHAVIOUR
//   Reset (reset=0, async): state=IDLE, r=0, rdata=16'h0000, count=0. Array not cleared.
//   Word index = addr[ADDR_W:1]; higher address bits are ignored (alias/wrap).
//   States:
//   - IDLE: mio_en=1 at an edge latches addr, r_w, data_size and wdata, loads
//     count=LATENCY-1, and moves to WAIT. Otherwise stays in IDLE.
//   - WAIT: mio_en=0 at an edge aborts the request: go to IDLE, no write, rdata unchanged.
//     Else if count!=0, decrement count. Else (count==0) perform the access at this edge
//     and go to DONE:
//       read:  rdata <= mem[idx] (full word; byte select is done by MDR logic).
//       word write: mem[idx] <= wdata; unaligned addr[0]=1 is treated as aligned.
//       byte write: addr[0]=0 writes mem[idx][7:0]; addr[0]=1 writes mem[idx][15:8];
//         both lanes take wdata[7:0]. The other byte is preserved.
//   - DONE: r=1 for exactly this cycle. The next edge always goes to IDLE, whatever
//     mio_en is, so one request never completes twice.
//   Timing: request seen in cycle 0 -> r=1 in cycle LATENCY+1.
//   Back-to-back: a new request can be accepted in the IDLE cycle right after DONE, so
//     the minimum request spacing is LATENCY+2 cycles.
//   Latched fields are used for the access. Changes on addr, wdata or r_w during WAIT
//     are ignored.
//   r is registered (state==DONE decode, no combinational path from inputs).
//   Reset asserted in WAIT or DONE: r drops at once and any pending write is discarded.
//   Simulation check: flag an error if LATENCY<1 at elaboration.
// TESTING
//   1. LATENCY=3, word write 16'h1234 @16'h3000: mio_en high in cycle 0 -> r=1 only in
//      cycle 4. A word read @16'h3000 then returns rdata=16'h1234 with r.
//   2. Byte write wdata=16'h00AB @16'h3001 over 16'h1234 -> word read gives 16'hAB34;
//      byte write 16'h00CD @16'h3000 -> 16'hABCD.
//   3. Abort: write 16'hFFFF @16'h3000, drop mio_en in cycle 2 -> r never asserts,
//      and a later read returns 16'hABCD.
//   4. Reset pulse (reset=0) during WAIT of a write 16'h5555 @16'h3002 -> r=0 and
//      rdata=0 immediately, state IDLE. A read @16'h3002 shows the prior contents.
//   5. Back-to-back: mio_en held high across two reads @16'h3000 then @16'h3001 ->
//      exactly two r pulses, in cycles 4 and 9.
//   6. ADDR_W=12 wrap: write 16'h0F0F @16'h0002, read @16'h2002 -> 16'h0F0F.

Source files
------------

// File: rtl/mem_responder.sv
// Memory-side responder for the MIO handshake: latches a request, waits LATENCY
// cycles, performs the word/byte access on a 2**ADDR_W x 16 array and pulses r.
module mem_responder #(
  parameter int LATENCY = 3,
  parameter int ADDR_W  = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mio_en,
  input  logic        r_w,
  input  logic        data_size,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        r
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  generate
    if (LATENCY < 1) begin : g_bad_latency
      $error("mem_responder: LATENCY must be >= 1");
    end
  endgenerate

  logic [1:0]        state_r;
  logic [1:0]        state_s;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  count_s;
  logic              access_s;
  logic [ADDR_W-1:0] idx_r;
  logic              lane_r;
  logic              r_w_r;
  logic              size_r;
  logic [15:0]       wdata_r;
  logic [15:0]       rdata_r;
  logic              r_r;
  logic              unused_addr_s;
  logic [15:0]       mem [0:(2**ADDR_W)-1];

  // Upper address bits alias onto the array and are deliberately dropped.
  assign unused_addr_s = ^addr[15:ADDR_W+1];

  // Byte lanes both take the low byte of the write data; the other lane is kept.
  function automatic logic [15:0] merge_word(input logic [15:0] old_word,
                                             input logic [15:0] wd,
                                             input logic        word_sz,
                                             input logic        hi_lane);
    logic [15:0] res;
    if (word_sz) begin
      res = wd;
    end else if (hi_lane) begin
      res = {wd[7:0], old_word[7:0]};
    end else begin
      res = {old_word[15:8], wd[7:0]};
    end
    return res;
  endfunction

  // Next-state and wait-counter decode.
  always_comb begin
    state_s  = state_r;
    count_s  = count_r;
    access_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (mio_en) begin
          state_s = WAIT;
          count_s = CNT_LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (!mio_en) begin
          state_s = IDLE;
        end else if (count_r != {CNT_W{1'b0}}) begin
          count_s = count_r - CNT_W'(1);
        end else begin
          access_s = 1'b1;
          state_s  = DONE;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Control state, latched request fields and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      count_r <= {CNT_W{1'b0}};
      idx_r   <= {ADDR_W{1'b0}};
      lane_r  <= 1'b0;
      r_w_r   <= 1'b0;
      size_r  <= 1'b0;
      wdata_r <= 16'h0000;
      rdata_r <= 16'h0000;
      r_r     <= 1'b0;
    end else begin
      state_r <= state_s;
      count_r <= count_s;
      r_r     <= access_s;
      if (state_r == IDLE && mio_en) begin
        idx_r   <= addr[ADDR_W:1];
        lane_r  <= addr[0];
        r_w_r   <= r_w;
        size_r  <= data_size;
        wdata_r <= wdata;
      end
      if (access_s && !r_w_r) begin
        rdata_r <= mem[idx_r];
      end
    end
  end

  // Array write port; not reset, contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (access_s && r_w_r) begin
      mem[idx_r] <= merge_word(mem[idx_r], wdata_r, size_r, lane_r);
    end
  end

  assign rdata = rdata_r;
  assign r     = r_r;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: latency, byte lanes, abort, reset, back-to-back, wrap.
module tb_mem_responder;

  logic        clk;
  logic        reset;
  logic        mio_en;
  logic        r_w;
  logic        data_size;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        r;

  int vectors;
  int miscompares;

  mem_responder #(.LATENCY(3), .ADDR_W(12)) dut (
    .clk(clk), .reset(reset), .mio_en(mio_en), .r_w(r_w), .data_size(data_size),
    .addr(addr), .wdata(wdata), .rdata(rdata), .r(r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Request issued in cycle 0; mio_en held until r is seen, then dropped.
  task automatic run_req(input logic rw, input logic sz, input logic [15:0] a,
                         input logic [15:0] wd, output int first_c, output int npulse,
                         output logic [15:0] rd);
    first_c = -1;
    npulse  = 0;
    rd      = 16'h0000;
    @(negedge clk);
    r_w = rw; data_size = sz; addr = a; wdata = wd; mio_en = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (r === 1'b1) begin
        npulse++;
        if (first_c < 0) begin
          first_c = c;
          rd = rdata;
        end
        mio_en = 1'b0;
      end
    end
    mio_en = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if (r !== 1'b0) begin miscompares++; $display("FAIL reset_r got %b want 0", r); end
    vectors++;
    if (rdata !== 16'h0000) begin miscompares++; $display("FAIL reset_rdata got %h want 0000", rdata); end
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (r !== 1'b0 || rdata !== 16'h0000) begin
      miscompares++; $display("FAIL post_reset got r=%b rdata=%h want r=0 rdata=0000", r, rdata);
    end
  endtask

  task automatic test_word_latency();
    int fc, np; logic [15:0] rd;
    run_req(1'b1, 1'b1, 16'h3000, 16'h1234, fc, np, rd);
    vectors++;
    if (fc !== 4 || np !== 1) begin miscompares++; $display("FAIL wr_latency got cycle=%0d pulses=%0d want 4/1", fc, np); end
    run_req(1'b0, 1'b1, 16'h3000, 16'h0000, fc, np, rd);
    vectors++;
    if (fc !== 4 || np !== 1) begin miscompares++; $display("FAIL rd_latency got cycle=%0d pulses=%0d want 4/1", fc, np); end
    vectors++;
    if (rd !== 16'h1234) begin miscompares++; $display("FAIL rd_word got %h want 1234", rd); end
  endtask

  task automatic test_byte_write();
    int fc, np; logic [15:0] rd;
    run_req(1'b1, 1'b0, 16'h3001, 16'h00AB, fc, np, rd);
    vectors++;
    if (rdata !== 16'h1234) begin miscompares++; $display("FAIL rdata_hold got %h want 1234", rdata); end
    run_req(1'b0, 1'b1, 16'h3000, 16'h0000, fc, np, rd);
    vectors++;
    if (rd !== 16'hAB34) begin miscompares++; $display("FAIL byte_hi got %h want ab34", rd); end
    run_req(1'b1, 1'b0, 16'h3000, 16'h00CD, fc, np, rd);
    run_req(1'b0, 1'b1, 16'h3000, 16'h0000, fc, np, rd);
    vectors++;
    if (rd !== 16'hABCD) begin miscompares++; $display("FAIL byte_lo got %h want abcd", rd); end
  endtask

  task automatic test_abort();
    int np; int fc; logic [15:0] rd;
    np = 0;
    @(negedge clk);
    r_w = 1'b1; data_size = 1'b1; addr = 16'h3000; wdata = 16'hFFFF; mio_en = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 2) mio_en = 1'b0;
      if (r === 1'b1) np++;
    end
    vectors++;
    if (np !== 0) begin miscompares++; $display("FAIL abort_r got %0d pulses want 0", np); end
    run_req(1'b0, 1'b1, 16'h3000, 16'h0000, fc, np, rd);
    vectors++;
    if (rd !== 16'hABCD) begin miscompares++; $display("FAIL abort_data got %h want abcd", rd); end
  endtask

  task automatic test_reset_mid();
    int fc, np; logic [15:0] rd;
    run_req(1'b1, 1'b1, 16'h3002, 16'h7777, fc, np, rd);
    run_req(1'b0, 1'b1, 16'h3000, 16'h0000, fc, np, rd);
    @(negedge clk);
    r_w = 1'b1; data_size = 1'b1; addr = 16'h3002; wdata = 16'h5555; mio_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    vectors++;
    if (r !== 1'b0 || rdata !== 16'h0000) begin
      miscompares++; $display("FAIL reset_wait got r=%b rdata=%h want r=0 rdata=0000", r, rdata);
    end
    mio_en = 1'b0;
    @(negedge clk); reset = 1'b1;
    np = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (r === 1'b1) np++;
    end
    vectors++;
    if (np !== 0) begin miscompares++; $display("FAIL reset_idle got %0d pulses want 0", np); end
    run_req(1'b0, 1'b1, 16'h3002, 16'h0000, fc, np, rd);
    vectors++;
    if (rd !== 16'h7777) begin miscompares++; $display("FAIL reset_nowrite got %h want 7777", rd); end
    // Reset landing in DONE must drop r immediately.
    @(negedge clk);
    r_w = 1'b0; data_size = 1'b1; addr = 16'h3000; mio_en = 1'b1;
    fc = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (r === 1'b1 && fc < 0) begin
        fc = c;
        reset = 1'b0;
        #1;
        vectors++;
        if (r !== 1'b0) begin miscompares++; $display("FAIL reset_done got r=%b want 0", r); end
        mio_en = 1'b0;
      end
    end
    reset = 1'b1;
    mio_en = 1'b0;
    vectors++;
    if (fc !== 4) begin miscompares++; $display("FAIL reset_done_cycle got %0d want 4", fc); end
  endtask

  task automatic test_back_to_back();
    int c1, c2, np; logic [15:0] d1, d2;
    c1 = -1; c2 = -1; np = 0; d1 = 16'h0000; d2 = 16'h0000;
    @(negedge clk);
    r_w = 1'b0; data_size = 1'b1; addr = 16'h3000; mio_en = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (r === 1'b1) begin
        np++;
        if (c1 < 0) begin c1 = c; d1 = rdata; addr = 16'h3001; end
        else if (c2 < 0) begin c2 = c; d2 = rdata; mio_en = 1'b0; end
      end
    end
    mio_en = 1'b0;
    vectors++;
    if (np !== 2 || c1 !== 4 || c2 !== 9) begin
      miscompares++; $display("FAIL b2b_timing got pulses=%0d at %0d,%0d want 2 at 4,9", np, c1, c2);
    end
    vectors++;
    if (d1 !== 16'hABCD || d2 !== 16'hABCD) begin
      miscompares++; $display("FAIL b2b_data got %h,%h want abcd,abcd", d1, d2);
    end
  endtask

  task automatic test_latched_fields();
    int fc, np; logic [15:0] rd;
    @(negedge clk);
    r_w = 1'b1; data_size = 1'b1; addr = 16'h3004; wdata = 16'h2468; mio_en = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 2) begin addr = 16'h3006; wdata = 16'hFFFF; r_w = 1'b0; end
      if (r === 1'b1) mio_en = 1'b0;
    end
    mio_en = 1'b0;
    run_req(1'b0, 1'b1, 16'h3004, 16'h0000, fc, np, rd);
    vectors++;
    if (rd !== 16'h2468) begin miscompares++; $display("FAIL latched got %h want 2468", rd); end
    run_req(1'b1, 1'b1, 16'h3007, 16'h1357, fc, np, rd);
    run_req(1'b0, 1'b1, 16'h3006, 16'h0000, fc, np, rd);
    vectors++;
    if (rd !== 16'h1357) begin miscompares++; $display("FAIL unaligned_word got %h want 1357", rd); end
  endtask

  task automatic test_wrap();
    int fc, np; logic [15:0] rd;
    run_req(1'b1, 1'b1, 16'h0002, 16'h0F0F, fc, np, rd);
    run_req(1'b0, 1'b1, 16'h2002, 16'h0000, fc, np, rd);
    vectors++;
    if (rd !== 16'h0F0F) begin miscompares++; $display("FAIL wrap got %h want 0f0f", rd); end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b0; mio_en = 1'b0; r_w = 1'b0; data_size = 1'b0;
    addr = 16'h0000; wdata = 16'h0000;
    test_reset();
    test_word_latency();
    test_byte_write();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_latched_fields();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
